regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (address_3/wr_data/wr_en) among NUM_REQ writeback
//  requesters (ALU, load unit, multiplier, ...) using round-robin arbitration and valid/ready handshakes.
//  After every reset it first sweeps all registers to zero (INIT), then arbitrates (RUN).
//  Sits between the execute/writeback stages and the register file; it is the port's only driver.
// PARAMETERS
//  NUM_REQ      3   number of writeback requesters (>=1)
//  REG_COUNT    32  registers in the file; AW = $clog2(REG_COUNT)
//  REG_WIDTH    32  data width
//  ZERO_REG_RO  1   1: writes to address 0 are accepted but never reach the file
// PORTS
//  clk_i          in   1                   clock
//  reset_ni       in   1                   asynchronous reset, active low
//  req_valid_i    in   NUM_REQ             requester i holds a write
//  req_ready_o    out  NUM_REQ             requester i's write is accepted this cycle
//  req_addr_i     in   NUM_REQ x AW        destination register, per requester
//  req_data_i     in   NUM_REQ x REG_WIDTH write data, per requester
//  rf_address_o   out  AW                  to register file address_3
//  rf_wr_data_o   out  REG_WIDTH           to register file wr_data
//  rf_wr_en_o     out  1                   to register file wr_en
//  init_done_o    out  1                   1 once the INIT sweep has finished
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-sweep or mid-write): state=INIT, init counter=0, rr pointer=0,
//    rf_wr_en_o=0, rf_address_o=0, rf_wr_data_o=0, init_done_o=0, req_ready_o=0. In-flight write is dropped.
//  - All rf_* outputs are registered (posedge); the file commits on the following negedge, so data is
//    stable for a half cycle before the write.
//  - INIT: one write per cycle: rf_wr_en_o=1, rf_address_o=cnt, rf_wr_data_o=0, cnt 0..REG_COUNT-1.
//    First INIT write appears the first posedge after reset release. req_ready_o=0 throughout.
//    When cnt==REG_COUNT-1 is issued, next state RUN; init_done_o=1 from the cycle after the last
//    INIT write is driven, and stays 1 until reset.
//  - RUN: grant = first i with req_valid_i[i], scanning ptr, ptr+1, ... modulo NUM_REQ.
//    req_ready_o = one-hot grant (combinational from valid; 0 when no valid). Handshake = valid&&ready.
//    Port never stalls: at most one acceptance per cycle, and a write is always possible when any valid.
//  - On acceptance of i at posedge k: rf_address_o/rf_wr_data_o <= req_addr_i[i]/req_data_i[i],
//    rf_wr_en_o <= 1 (0 if ZERO_REG_RO && addr==0); ptr <= (i+1) mod NUM_REQ. Write visible in file
//    after negedge of cycle k+1 (latency 1 cycle from handshake to commit).
//  - No acceptance: rf_wr_en_o <= 0, rf_address_o/rf_wr_data_o hold, ptr holds.
//  - Requesters must hold valid/addr/data stable until ready; dropping valid without ready is allowed.
//  - Two requesters targeting the same register: serialized in grant order; later grant wins in file.
//  - NUM_REQ==1: ready = valid, ptr fixed at 0.
// STRUCTURE
//  - regfile_pkg: localparam AW helper, typedef enum logic {WB_INIT, WB_RUN} wb_state_t,
//    typedef struct {addr, data} rf_wr_t.
//  - Sub-module rr_arbiter #(N): valid[N], ptr in -> one-hot grant, grant index; pure combinational.
//    Pointer register, INIT counter, FSM and output register live in regfile_wb_arbiter.
// TESTING (bench pairs with register_file model, REG_COUNT=32, NUM_REQ=3)
//  - Preload file nonzero, pulse reset_ni low, release -> 32 writes addr 0..31 data 0 on consecutive
//    cycles, req_ready_o=0 throughout, init_done_o=1 the cycle after addr 31; all regs read 0.
//  - RUN, all three valid every cycle, addrs 1/2/3 -> grants 0,1,2,0,1,2...; exactly one ready per cycle.
//  - Req1 writes r5=0xDEADBEEF at posedge k -> rf_wr_en_o=1, addr 5 in cycle k+1; r5 reads 0xDEADBEEF after.
//  - Req0 writes r0=0x1234 with ZERO_REG_RO=1 -> ready=1, rf_wr_en_o stays 0, r0 still 0.
//  - Req0 and req2 both target r7 (0xA, 0xB), ptr=2 -> req2 first, then req0; r7 ends 0xA.
//  - Assert reset_ni mid-INIT (cnt=10) and mid-RUN write -> rf_wr_en_o=0 immediately, sweep restarts at 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
//  - wb_state_t : arbiter FSM state (zeroing sweep, then arbitration)
//  - rf_wr_t    : one register-file write (address + data) at the default 32 x 32 geometry
//  - idx_width  : index width for a count, never below one bit
package regfile_pkg;

  localparam int unsigned DefRegCount = 32;
  localparam int unsigned DefRegWidth = 32;
  localparam int unsigned DefAw       = 5;

  typedef enum logic {
    WB_INIT,
    WB_RUN
  } wb_state_t;

  typedef struct packed {
    logic [DefAw-1:0]       addr;
    logic [DefRegWidth-1:0] data;
  } rf_wr_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans requesters starting at ptr_i, wrapping modulo N, and grants the first valid one.
//  valid_i : per-requester request
//  ptr_i   : highest-priority requester this cycle (must be < N)
//  grant_o : one-hot grant, all zero when no request
//  idx_o   : index of the granted requester (0 when none)
//  any_o   : at least one request is present
module rr_arbiter #(
  parameter int unsigned  N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int unsigned   cand;
    logic [PW-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr_i) + k) % N;
      cand_idx = PW'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register file's single write port.
// After reset it zeroes every register (one write per cycle), then arbitrates NUM_REQ
// writeback requesters with valid/ready handshakes. All rf_* outputs are registered; the
// file commits them on the following negedge.
//  clk_i / reset_ni : clock, asynchronous active-low reset
//  req_valid_i      : requester holds a write
//  req_ready_o      : requester's write is accepted this cycle (one-hot or zero)
//  req_addr_i       : per-requester destination register
//  req_data_i       : per-requester write data
//  rf_address_o     : register file address_3
//  rf_wr_data_o     : register file wr_data
//  rf_wr_en_o       : register file wr_en
//  init_done_o      : zeroing sweep finished
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned  NUM_REQ     = 3,
  parameter int unsigned  REG_COUNT   = 32,
  parameter int unsigned  REG_WIDTH   = 32,
  parameter bit           ZERO_REG_RO = 1'b1,
  localparam int unsigned AW          = idx_width(REG_COUNT)
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][AW-1:0]         req_addr_i,
  input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]  req_data_i,
  output logic [AW-1:0]                      rf_address_o,
  output logic [REG_WIDTH-1:0]               rf_wr_data_o,
  output logic                               rf_wr_en_o,
  output logic                               init_done_o
);

  localparam int unsigned   PW      = idx_width(NUM_REQ);
  localparam logic [AW-1:0] LastCnt = AW'(REG_COUNT - 1);
  localparam logic [PW-1:0] LastReq = PW'(NUM_REQ - 1);

  wb_state_t            state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;

  logic [NUM_REQ-1:0]   grant;
  logic [PW-1:0]        grant_idx;
  logic                 grant_any;
  logic                 run;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign run         = (state_q == WB_RUN);
  assign req_ready_o = run ? grant : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = 1'b0;
    // Raised one cycle after the final sweep write is on the port.
    done_d  = done_q | run;
    unique case (state_q)
      WB_INIT: begin
        en_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LastCnt) begin
          state_d = WB_RUN;
          cnt_d   = '0;
        end
      end
      WB_RUN: begin
        if (grant_any) begin
          addr_d = req_addr_i[grant_idx];
          data_d = req_data_i[grant_idx];
          // Writes to r0 still handshake so the requester is released, but never commit.
          en_d   = !(ZERO_REG_RO && (req_addr_i[grant_idx] == '0));
          ptr_d  = (grant_idx == LastReq) ? '0 : grant_idx + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= WB_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign rf_address_o = addr_q;
  assign rf_wr_data_o = data_q;
  assign rf_wr_en_o   = en_q;
  assign init_done_o  = done_q;

endmodule
